// File: rtl/a1_checker_if.sv
// Stimulus/response bundle between a test driver and the a1_checker.
// The driver (master) supplies the vector stream and the observed DUT
// response; the checker (slave) reports run status and first-failure data.
interface a1_checker_if;
    logic       start;
    logic       vec_valid;
    logic [2:0] vec_a;
    logic [1:0] resp_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [7:0] vec_cnt;
    logic [2:0] fail_vec;
    logic [1:0] fail_resp;
    logic [1:0] fail_exp;

    modport master (
        output start, vec_valid, vec_a, resp_b,
        input  busy, done, pass, err_cnt, vec_cnt, fail_vec, fail_resp, fail_exp
    );

    modport slave (
        input  start, vec_valid, vec_a, resp_b,
        output busy, done, pass, err_cnt, vec_cnt, fail_vec, fail_resp, fail_exp
    );
endinterface

// File: rtl/a1_checker.sv
// Response checker for a 3-in/2-out combinational block. Each accepted
// vector is held for SETTLE cycles, then the response is sampled once and
// compared against a truth table; mismatch count and the first failing
// vector are reported when NVEC vectors have been checked.
module a1_checker #(
    parameter logic [15:0] EXP_TABLE = 16'h9494,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned NVEC      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    a1_checker_if.slave bus
);
    localparam logic [7:0] SETTLE_L = 8'(SETTLE);
    localparam logic [7:0] NVEC_L   = 8'(NVEC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t     state;
    logic [2:0] vec_q;
    logic [7:0] settle_cnt;
    logic       first_fail;

    logic       busy_q, done_q, pass_q;
    logic [7:0] err_cnt_q, vec_cnt_q;
    logic [2:0] fail_vec_q;
    logic [1:0] fail_resp_q, fail_exp_q;

    // Expected response for the latched vector and next-count values used in CHECK.
    logic [1:0] exp_resp;
    logic       mismatch;
    logic [7:0] err_nxt;
    logic [7:0] vec_nxt;

    // Table lookup and saturating error increment for the CHECK cycle.
    always_comb begin
        exp_resp = EXP_TABLE[{vec_q, 1'b0} +: 2];
        mismatch = (bus.resp_b != exp_resp);
        err_nxt  = (mismatch && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        vec_nxt  = vec_cnt_q + 8'd1;
    end

    // Run sequencing FSM; all status outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            vec_q       <= 3'd0;
            settle_cnt  <= 8'd0;
            first_fail  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= 8'd0;
            vec_cnt_q   <= 8'd0;
            fail_vec_q  <= 3'd0;
            fail_resp_q <= 2'd0;
            fail_exp_q  <= 2'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // A vec_valid coinciding with start is dropped: the run
                    // only begins accepting vectors from WAIT.
                    if (bus.start) begin
                        state       <= ST_WAIT;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_cnt_q   <= 8'd0;
                        vec_cnt_q   <= 8'd0;
                        fail_vec_q  <= 3'd0;
                        fail_resp_q <= 2'd0;
                        fail_exp_q  <= 2'd0;
                        first_fail  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.vec_valid) begin
                        vec_q      <= bus.vec_a;
                        settle_cnt <= SETTLE_L;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Counter was loaded with SETTLE, so leaving at 1 gives
                    // exactly SETTLE cycles here.
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settle_cnt == 8'd1)
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    vec_cnt_q <= vec_nxt;
                    err_cnt_q <= err_nxt;
                    if (mismatch && !first_fail) begin
                        first_fail  <= 1'b1;
                        fail_vec_q  <= vec_q;
                        fail_resp_q <= bus.resp_b;
                        fail_exp_q  <= exp_resp;
                    end
                    if (vec_nxt == NVEC_L) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_nxt == 8'd0);
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.vec_cnt   = vec_cnt_q;
    assign bus.fail_vec  = fail_vec_q;
    assign bus.fail_resp = fail_resp_q;
    assign bus.fail_exp  = fail_exp_q;
endmodule

// File: tb/tb_a1_checker.sv
// Directed bench for a1_checker: a default-parameter instance and a
// NVEC=255/SETTLE=1 instance share one stimulus set, selected by sel.
module tb_a1_checker;
    logic clk = 1'b0;
    logic rst_n;
    logic sel;
    logic st, vv;
    logic [2:0] va;
    logic [1:0] rb;

    always #5 clk = ~clk;

    a1_checker_if bus0 ();
    a1_checker_if bus1 ();

    assign bus0.start     = !sel && st;
    assign bus0.vec_valid = !sel && vv;
    assign bus0.vec_a     = va;
    assign bus0.resp_b    = rb;
    assign bus1.start     = sel && st;
    assign bus1.vec_valid = sel && vv;
    assign bus1.vec_a     = va;
    assign bus1.resp_b    = rb;

    a1_checker u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    a1_checker #(.EXP_TABLE(16'h9494), .SETTLE(1), .NVEC(255))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    logic       o_busy, o_done, o_pass;
    logic [7:0] o_err, o_vec;
    logic [2:0] o_fvec;
    logic [1:0] o_fresp, o_fexp;

    // Observe whichever instance is currently selected.
    always_comb begin
        o_busy  = sel ? bus1.busy      : bus0.busy;
        o_done  = sel ? bus1.done      : bus0.done;
        o_pass  = sel ? bus1.pass      : bus0.pass;
        o_err   = sel ? bus1.err_cnt   : bus0.err_cnt;
        o_vec   = sel ? bus1.vec_cnt   : bus0.vec_cnt;
        o_fvec  = sel ? bus1.fail_vec  : bus0.fail_vec;
        o_fresp = sel ? bus1.fail_resp : bus0.fail_resp;
        o_fexp  = sel ? bus1.fail_exp  : bus0.fail_exp;
    end

    typedef struct {
        logic [7:0] vc;
        logic [7:0] ec;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int m_vec, m_err;
    bit m_ff;
    logic [2:0] m_fv;
    logic [1:0] m_fr, m_fe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_resp(input logic [2:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

    task automatic model_clear();
        m_vec = 0; m_err = 0; m_ff = 1'b0;
        m_fv = 3'd0; m_fr = 2'd0; m_fe = 2'd0;
    endtask

    // Pulse start (optionally with vec_valid) and confirm the run opened
    // without accepting the coincident vector.
    task automatic start_run(input int settle, input bit with_vv);
        model_clear();
        st = 1'b1; vv = with_vv; va = 3'd5;
        @(posedge clk); #1;
        st = 1'b0; vv = 1'b0;
        chk("start_busy", o_busy, 1);
        chk("start_done", o_done, 0);
        chk("start_pass", o_pass, 0);
        chk("start_err", o_err, 0);
        chk("start_vec", o_vec, 0);
        if (with_vv) begin
            repeat (settle + 2) @(posedge clk);
            #1;
            chk("start_vv_ignored", o_vec, 0);
        end
    endtask

    // Drive one vector. strict: resp_b is correct only in the cycle before
    // the expected sampling edge. noise: vec_valid stays high with a
    // different vector through SETTLE and CHECK.
    task automatic do_vec(input logic [2:0] v, input logic [1:0] r, input int settle,
                          input bit strict, input bit noise);
        logic [1:0] e;
        exp_t       got;
        e = ref_resp(v);
        m_vec++;
        if (r != e) begin
            if (m_err < 255) m_err++;
            if (!m_ff) begin
                m_ff = 1'b1; m_fv = v; m_fr = r; m_fe = e;
            end
        end
        sb.push_back('{vc: 8'(m_vec), ec: 8'(m_err)});
        va = v; vv = 1'b1; rb = strict ? ~r : r;
        @(posedge clk); #1;
        if (noise) va = v ^ 3'b001;
        else vv = 1'b0;
        repeat (settle) @(posedge clk);
        #1;
        chk("vec_cnt_before_sample", o_vec, 32'(m_vec - 1));
        rb = r;
        @(posedge clk); #1;
        vv = 1'b0;
        if (strict) rb = ~r;
        got = sb.pop_front();
        chk("vec_cnt", o_vec, got.vc);
        chk("err_cnt", o_err, got.ec);
    endtask

    task automatic chk_final(input string tag);
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_pass"}, o_pass, (m_err == 0) ? 1 : 0);
        chk({tag, "_err"}, o_err, m_err);
        chk({tag, "_vec"}, o_vec, m_vec);
        chk({tag, "_fvec"}, o_fvec, m_fv);
        chk({tag, "_fresp"}, o_fresp, m_fr);
        chk({tag, "_fexp"}, o_fexp, m_fe);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; st = 1'b0; vv = 1'b0; va = 3'd0; rb = 2'd0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_pass", o_pass, 0);
            chk("rst_err", o_err, 0);
            chk("rst_vec", o_vec, 0);
            chk("rst_fvec", o_fvec, 0);
            chk("rst_fresp", o_fresp, 0);
            chk("rst_fexp", o_fexp, 0);
        end
        sel = 1'b0;
        rst_n = 1'b1;

        // No start: vec_valid must do nothing.
        vv = 1'b1; va = 3'd3; rb = 2'd0;
        repeat (8) @(posedge clk);
        #1;
        vv = 1'b0;
        chk("idle_busy", o_busy, 0);
        chk("idle_vec", o_vec, 0);

        // All pass with tight response timing; start carries a stray vec_valid.
        start_run(4, 1'b1);
        for (int i = 0; i < 8; i++)
            do_vec(3'(i), ref_resp(3'(i)), 4, 1'b1, 1'b0);
        chk_final("allpass");
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", o_done, 1);
        chk("pass_held", o_pass, 1);

        // Single error at vector 3, with ignored start in WAIT and vec_valid noise.
        start_run(4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                st = 1'b1;
                @(posedge clk); #1;
                st = 1'b0;
                chk("start_in_wait_vec", o_vec, 2);
                chk("start_in_wait_busy", o_busy, 1);
            end
            do_vec(3'(i), (i == 3) ? 2'b01 : ref_resp(3'(i)), 4, 1'b0, 1'b1);
        end
        chk_final("singleerr");
        chk("singleerr_fvec_abs", o_fvec, 3);
        chk("singleerr_fresp_abs", o_fresp, 1);
        chk("singleerr_fexp_abs", o_fexp, 2);

        // Reset while settling the fourth vector.
        start_run(4, 1'b0);
        for (int i = 0; i < 3; i++)
            do_vec(3'(i + 4), ref_resp(3'(i + 4)), 4, 1'b0, 1'b0);
        vv = 1'b1; va = 3'd7;
        @(posedge clk); #1;
        vv = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_vec", o_vec, 0);
        chk("midrst_err", o_err, 0);
        chk("midrst_done", o_done, 0);
        rst_n = 1'b1;
        vv = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        vv = 1'b0;
        chk("midrst_idle_vec", o_vec, 0);
        chk("midrst_idle_busy", o_busy, 0);
        start_run(4, 1'b0);
        for (int i = 0; i < 8; i++)
            do_vec(3'(7 - i), ref_resp(3'(7 - i)), 4, 1'b0, 1'b0);
        chk_final("clean");

        // Saturation: 255 vectors all wrong, first at vector 1.
        sel = 1'b1;
        #1;
        start_run(1, 1'b0);
        for (int i = 0; i < 255; i++)
            do_vec(3'((i + 1) % 8), ~ref_resp(3'((i + 1) % 8)), 1, 1'b1, 1'b0);
        chk_final("sat");
        chk("sat_err_abs", o_err, 255);
        chk("sat_fvec_abs", o_fvec, 1);
        chk("sat_fresp_abs", o_fresp, 2);
        chk("sat_fexp_abs", o_fexp, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
